// File: rtl/f8_pkg.sv
// f8_pkg: shared constants, types and helpers for the f8 register file.
// Contents: LANE_W (bits per byte lane), lane_mask_t (lane mask of the
// default 16-bit configuration) and addr_w() (register address width).
package f8_pkg;
    localparam int LANE_W = 8;
    localparam int DEF_LANES = 2;
    typedef logic [DEF_LANES-1:0] lane_mask_t;
    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/f8_regfile_mp_if.sv
// f8_regfile_mp_if: read, write and scoreboard bus of the f8 register file.
// master: core side (drives addresses, write data/enables, pend_*).
// slave: register file side (drives rd_data, rd_next, rd_busy, pend_err).
interface f8_regfile_mp_if
    import f8_pkg::*;
#(
    parameter int NREGS = 3,
    parameter int WIDTH = 16,
    parameter int NRD   = 3,
    parameter int NWR   = 2
);
    localparam int AW = addr_w(NREGS);
    localparam int LANES = WIDTH / LANE_W;
    logic [NRD-1:0][AW-1:0]    rd_addr;
    logic [NRD-1:0][WIDTH-1:0] rd_data;
    logic [NRD-1:0][WIDTH-1:0] rd_next;
    logic [NRD-1:0][LANES-1:0] rd_busy;
    logic [NWR-1:0][AW-1:0]    wr_addr;
    logic [NWR-1:0][WIDTH-1:0] wr_data;
    logic [NWR-1:0][LANES-1:0] wr_en;
    logic                      pend_set;
    logic [AW-1:0]             pend_addr;
    logic [LANES-1:0]          pend_lanes;
    logic                      pend_err;
    modport master (
        output rd_addr, wr_addr, wr_data, wr_en, pend_set, pend_addr, pend_lanes,
        input  rd_data, rd_next, rd_busy, pend_err
    );
    modport slave (
        input  rd_addr, wr_addr, wr_data, wr_en, pend_set, pend_addr, pend_lanes,
        output rd_data, rd_next, rd_busy, pend_err
    );
endinterface

// File: rtl/f8_lane_merge.sv
// f8_lane_merge: priority merge of all write ports into one register.
// old_val: stored value; hit: per-port address match; wr_en/wr_data: port
// lanes and data; new_val: value after the edge; written: lanes any port writes.
module f8_lane_merge
    import f8_pkg::*;
#(
    parameter int NWR   = 2,
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]                      old_val,
    input  logic [NWR-1:0]                        hit,
    input  logic [NWR-1:0][WIDTH/LANE_W-1:0]      wr_en,
    input  logic [NWR-1:0][WIDTH-1:0]             wr_data,
    output logic [WIDTH-1:0]                      new_val,
    output logic [WIDTH/LANE_W-1:0]               written
);
    localparam int LANES = WIDTH / LANE_W;
    // ascending port order so the highest-index writer lands last and wins
    always_comb begin
        new_val = old_val;
        written = '0;
        for (int p = 0; p < NWR; p++)
            for (int k = 0; k < LANES; k++)
                if (hit[p] && wr_en[p][k]) begin
                    new_val[k*LANE_W +: LANE_W] = wr_data[p][k*LANE_W +: LANE_W];
                    written[k] = 1'b1;
                end
    end
endmodule

// File: rtl/f8_regfile_mp.sv
// f8_regfile_mp: multi-port byte-lane register file with forwarded reads and
// a per-lane pending-load scoreboard.
// clk: rising-edge clock; reset_n: asynchronous active-low reset;
// bus: reads (rd_addr -> rd_data/rd_next/rd_busy), writes (wr_addr/wr_data/
// wr_en), load marking (pend_set/pend_addr/pend_lanes) and sticky pend_err.
module f8_regfile_mp
    import f8_pkg::*;
#(
    parameter int              NREGS       = 3,
    parameter int              WIDTH       = 16,
    parameter int              NRD         = 3,
    parameter int              NWR         = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic            clk,
    input logic            reset_n,
    f8_regfile_mp_if.slave bus
);
    localparam int AW = addr_w(NREGS);
    localparam int LANES = WIDTH / LANE_W;
    logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d, merged;
    logic [NREGS-1:0][LANES-1:0] pend_q, pend_d, written, set_m;
    logic                        err_q, err_d;
    // out-of-range addresses match no register, so they are ignored
    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        logic [NWR-1:0] hit;
        for (genvar p = 0; p < NWR; p++) begin : g_hit
            assign hit[p] = bus.wr_addr[p] == AW'(r);
        end
        assign set_m[r] = (bus.pend_set && bus.pend_addr == AW'(r)) ? bus.pend_lanes : '0;
        f8_lane_merge #(.NWR(NWR), .WIDTH(WIDTH)) u_merge (
            .old_val (regs_q[r]),
            .hit     (hit),
            .wr_en   (bus.wr_en),
            .wr_data (bus.wr_data),
            .new_val (merged[r]),
            .written (written[r])
        );
    end
    // a new load supersedes a same-cycle writeback, so set is ORed after clear
    always_comb begin
        regs_d = merged;
        pend_d = pend_q;
        err_d = err_q;
        for (int i = 0; i < NREGS; i++) begin
            pend_d[i] = (pend_q[i] & ~written[i]) | set_m[i];
            err_d = err_d | (|(set_m[i] & pend_q[i] & ~written[i]));
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= {NREGS{RESET_VALUE}};
            pend_q <= '0;
            err_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
            err_q <= err_d;
        end
    end
    // rd_next falls back to stored data while in reset, since no edge will commit
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            bus.rd_data[i] = '0;
            bus.rd_next[i] = '0;
            bus.rd_busy[i] = '0;
            for (int j = 0; j < NREGS; j++)
                if (bus.rd_addr[i] == AW'(j)) begin
                    bus.rd_data[i] = regs_q[j];
                    bus.rd_next[i] = reset_n ? merged[j] : regs_q[j];
                    bus.rd_busy[i] = pend_q[j];
                end
        end
    end
    assign bus.pend_err = err_q;
endmodule

// File: tb/tb_f8_regfile_mp.sv
// tb_f8_regfile_mp: random and directed checks of two f8_regfile_mp configs
// (3x16 bit, 2 write ports; 5x32 bit, 3 write ports) against a lane-level model.
module tb_f8_regfile_mp;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;
    localparam logic [31:0] RV_B = 32'h1234_5678;
    f8_regfile_mp_if #(.NREGS(3), .WIDTH(16), .NRD(3), .NWR(2)) ia ();
    f8_regfile_mp_if #(.NREGS(5), .WIDTH(32), .NRD(3), .NWR(3)) ib ();
    f8_regfile_mp #(.NREGS(3), .WIDTH(16), .NRD(3), .NWR(2), .RESET_VALUE(16'h0)) u_a (
        .clk(clk), .reset_n(reset_n), .bus(ia.slave));
    f8_regfile_mp #(.NREGS(5), .WIDTH(32), .NRD(3), .NWR(3), .RESET_VALUE(RV_B)) u_b (
        .clk(clk), .reset_n(reset_n), .bus(ib.slave));
    int          nregs [2] = '{3, 5};
    int          aw    [2] = '{2, 3};
    int          lanes [2] = '{2, 4};
    int          nwr   [2] = '{2, 3};
    logic [31:0] rv    [2] = '{32'h0, RV_B};
    logic [31:0] mem  [2][8];
    logic [3:0]  pend [2][8];
    logic        err  [2];
    int          s_wa [2][3];
    logic [31:0] s_wd [2][3];
    logic [3:0]  s_we [2][3];
    int          s_ra [2][3];
    logic        s_ps [2];
    int          s_pa [2];
    logic [3:0]  s_pl [2];
    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] d, n;
    logic [3:0]  b;
    logic        e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 8; r++) begin
                mem[c][r] = rv[c];
                pend[c][r] = '0;
            end
            err[c] = 1'b0;
        end
    endtask

    // value register a holds after this edge: per lane, the highest port that writes it
    function automatic logic [31:0] exp_next(input int c, input int a);
        logic [31:0] v;
        if (a >= nregs[c]) return 32'h0;
        v = mem[c][a];
        for (int k = 0; k < lanes[c]; k++)
            for (int p = nwr[c] - 1; p >= 0; p--)
                if (s_wa[c][p] == a && s_we[c][p][k]) begin
                    v[k*8 +: 8] = s_wd[c][p][k*8 +: 8];
                    break;
                end
        return v;
    endfunction

    task automatic model_commit(input int c);
        logic wr, set;
        for (int r = 0; r < nregs[c]; r++) begin
            for (int k = 0; k < lanes[c]; k++) begin
                wr = 1'b0;
                for (int p = 0; p < nwr[c]; p++)
                    if (s_wa[c][p] == r && s_we[c][p][k]) wr = 1'b1;
                set = s_ps[c] && s_pa[c] == r && s_pl[c][k];
                if (set && pend[c][r][k] && !wr) err[c] = 1'b1;
                pend[c][r][k] = set | (pend[c][r][k] & ~wr);
            end
            mem[c][r] = exp_next(c, r);
        end
    endtask

    task automatic idle(input int c);
        for (int p = 0; p < 3; p++) begin
            s_wa[c][p] = 0;
            s_wd[c][p] = '0;
            s_we[c][p] = '0;
            s_ra[c][p] = p;
        end
        s_ps[c] = 1'b0;
        s_pa[c] = 0;
        s_pl[c] = '0;
    endtask

    task automatic rand_stim(input int c);
        int top;
        top = (1 << aw[c]) - 1;
        for (int p = 0; p < 3; p++) begin
            s_wa[c][p] = $urandom_range(0, top);
            s_wd[c][p] = $urandom;
            s_we[c][p] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
            s_ra[c][p] = $urandom_range(0, top);
        end
        s_ps[c] = ($urandom_range(0, 3) == 0);
        s_pa[c] = $urandom_range(0, top);
        s_pl[c] = 4'($urandom_range(0, 15));
    endtask

    task automatic drive(input int c);
        if (c == 0) begin
            for (int p = 0; p < 2; p++) begin
                ia.wr_addr[p] = 2'(s_wa[0][p]);
                ia.wr_data[p] = s_wd[0][p][15:0];
                ia.wr_en[p] = s_we[0][p][1:0];
            end
            for (int i = 0; i < 3; i++) ia.rd_addr[i] = 2'(s_ra[0][i]);
            ia.pend_set = s_ps[0];
            ia.pend_addr = 2'(s_pa[0]);
            ia.pend_lanes = s_pl[0][1:0];
        end else begin
            for (int p = 0; p < 3; p++) begin
                ib.wr_addr[p] = 3'(s_wa[1][p]);
                ib.wr_data[p] = s_wd[1][p];
                ib.wr_en[p] = s_we[1][p];
            end
            for (int i = 0; i < 3; i++) ib.rd_addr[i] = 3'(s_ra[1][i]);
            ib.pend_set = s_ps[1];
            ib.pend_addr = 3'(s_pa[1]);
            ib.pend_lanes = s_pl[1];
        end
    endtask

    task automatic observe(input int c, input int i, output logic [31:0] od,
                           output logic [31:0] on, output logic [3:0] ob, output logic oe);
        if (c == 0) begin
            od = {16'h0, ia.rd_data[i]};
            on = {16'h0, ia.rd_next[i]};
            ob = {2'b00, ia.rd_busy[i]};
            oe = ia.pend_err;
        end else begin
            od = ib.rd_data[i];
            on = ib.rd_next[i];
            ob = ib.rd_busy[i];
            oe = ib.pend_err;
        end
    endtask

    task automatic check(input int c);
        logic [31:0] od, on, ed;
        logic [3:0]  ob;
        logic        oe;
        int          a;
        for (int i = 0; i < 3; i++) begin
            observe(c, i, od, on, ob, oe);
            a = s_ra[c][i];
            ed = (a < nregs[c]) ? mem[c][a] : 32'h0;
            chk($sformatf("c%0d rd_data[%0d] addr=%0d", c, i, a), od, ed);
            chk($sformatf("c%0d rd_next[%0d] addr=%0d", c, i, a), on, reset_n ? exp_next(c, a) : ed);
            chk($sformatf("c%0d rd_busy[%0d] addr=%0d", c, i, a), {28'h0, ob},
                (a < nregs[c]) ? {28'h0, pend[c][a]} : 32'h0);
        end
        observe(c, 0, od, on, ob, oe);
        chk($sformatf("c%0d pend_err", c), {31'h0, oe}, {31'h0, err[c]});
    endtask

    task automatic pre();
        @(negedge clk);
        drive(0);
        drive(1);
        #1;
        check(0);
        check(1);
    endtask

    task automatic post();
        @(posedge clk);
        if (reset_n) begin
            model_commit(0);
            model_commit(1);
        end
    endtask

    task automatic tick();
        pre();
        post();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        idle(0);
        idle(1);
        drive(0);
        drive(1);
        #1 reset_n = 1'b0;
        #1;
        check(0);
        check(1);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (300) begin
            rand_stim(0);
            rand_stim(1);
            tick();
        end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check(0);
        check(1);
        idle(0);
        idle(1);
        drive(0);
        drive(1);
        @(negedge clk) reset_n = 1'b1;
        s_wa[0][0] = 1; s_wd[0][0] = 32'hAA55; s_we[0][0] = 4'b0001; s_ra[0][0] = 1;
        pre();
        observe(0, 0, d, n, b, e);
        chk("fwd rd_next reg1", n, 32'h0055);
        post();
        idle(0); s_ra[0][0] = 1;
        pre();
        observe(0, 0, d, n, b, e);
        chk("lane write rd_data reg1", d, 32'h0055);
        post();
        idle(0);
        s_wa[0][0] = 2; s_wd[0][0] = 32'h1111; s_we[0][0] = 4'b0011;
        s_wa[0][1] = 2; s_wd[0][1] = 32'h2222; s_we[0][1] = 4'b0011;
        tick();
        idle(0); s_ra[0][0] = 2;
        pre();
        observe(0, 0, d, n, b, e);
        chk("port conflict reg2", d, 32'h2222);
        post();
        idle(0); s_ps[0] = 1'b1; s_pa[0] = 0; s_pl[0] = 4'b0011;
        tick();
        idle(0); s_we[0][0] = 4'b0001; s_wd[0][0] = 32'h0077;
        pre();
        observe(0, 0, d, n, b, e);
        chk("busy after set", {28'h0, b}, 32'h3);
        post();
        idle(0); s_we[0][0] = 4'b0010; s_wd[0][0] = 32'h6600;
        pre();
        observe(0, 0, d, n, b, e);
        chk("busy after wb lane0", {28'h0, b}, 32'h2);
        post();
        idle(0);
        pre();
        observe(0, 0, d, n, b, e);
        chk("busy after wb lane1", {28'h0, b}, 32'h0);
        post();
        idle(0); s_wd[0][0] = 32'h00C3; s_we[0][0] = 4'b0001;
        s_ps[0] = 1'b1; s_pa[0] = 0; s_pl[0] = 4'b0001;
        tick();
        idle(0);
        pre();
        observe(0, 0, d, n, b, e);
        chk("race busy", {28'h0, b}, 32'h1);
        chk("race pend_err", {31'h0, e}, 32'h0);
        chk("race data", {24'h0, d[7:0]}, 32'hC3);
        post();
        idle(0); s_ps[0] = 1'b1; s_pa[0] = 0; s_pl[0] = 4'b0001;
        tick();
        idle(0);
        repeat (3) tick();
        pre();
        observe(0, 0, d, n, b, e);
        chk("pend_err sticky", {31'h0, e}, 32'h1);
        post();
        idle(1);
        s_wa[1][0] = 7; s_wd[1][0] = 32'hFFFF_FFFF; s_we[1][0] = 4'hF;
        s_ra[1][0] = 7; s_ra[1][1] = 6;
        pre();
        observe(1, 0, d, n, b, e);
        chk("oob rd_next addr7", n, 32'h0);
        observe(1, 1, d, n, b, e);
        chk("oob rd_data addr6", d, 32'h0);
        post();
        idle(1); s_wa[1][2] = 3; s_wd[1][2] = 32'hDE00_0000; s_we[1][2] = 4'b1000;
        tick();
        idle(1); s_ra[1][0] = 3;
        pre();
        observe(1, 0, d, n, b, e);
        chk("lane3 write reg3", d, 32'hDE34_5678);
        post();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
